// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: byte-level sequencer in front of a byte-loaded AES-256 core.
// Caches the 32-byte key and replays it for every 16-byte block, forwards
// plaintext straight through to the core, starts the core, waits for done
// under a watchdog, then streams the 128-bit result back as 16 bytes.
//
// Optional build macro: AES_SEQ_BLKCNT_EN adds output blk_done_cnt[31:0],
// a wrapping count of fully delivered ciphertext blocks.
//
// state   | meaning
// S_IDLE  | key loading allowed; waiting for first plaintext byte
// S_LOAD  | key replay to core and plaintext forwarding, concurrently
// S_START | one-cycle core_start pulse, watchdog armed
// S_WAIT  | waiting for core_done, watchdog counting down
// S_OUT   | streaming 16 ciphertext bytes to host
module aes_seq_ctrl #(
  parameter int WDOG_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [7:0]   key_byte,
  output logic         key_ready,
  input  logic         blk_valid,
  input  logic [7:0]   blk_byte,
  output logic         blk_ready,
  output logic         out_valid,
  output logic [7:0]   out_byte,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         key_loaded,
  output logic         err,
  output logic         core_ld_key_valid,
  output logic [7:0]   core_ld_key_byte,
  input  logic         core_ld_key_ready,
  output logic         core_ld_state_valid,
  output logic [7:0]   core_ld_state_byte,
  input  logic         core_ld_state_ready,
  output logic         core_start,
  input  logic [127:0] core_state_out,
  input  logic         core_done
`ifdef AES_SEQ_BLKCNT_EN
  , output logic [31:0] blk_done_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_OUT} state_t;

  state_t            st, st_nxt;
  logic [7:0]        cache [32];
  logic [4:0]        key_cnt;
  logic [4:0]        blk_cnt;
  logic [5:0]        rkey_cnt;
  logic [3:0]        out_cnt;
  logic [WDOG_W-1:0] wdog;
  logic [127:0]      out_buf;
  logic [127:0]      out_sh;
  logic              key_acc, blk_acc, rkey_acc, out_acc, wdog_tc, load_done, blk_fin;

  // A pending key byte in S_IDLE takes priority over plaintext.
  assign key_ready = (st == S_IDLE) && (blk_cnt == 5'd0);
  assign blk_ready = key_loaded && (st == S_IDLE || st == S_LOAD) && core_ld_state_ready
                     && !blk_cnt[4] && !(st == S_IDLE && key_valid);
  assign key_acc   = key_valid && key_ready;
  assign blk_acc   = blk_valid && blk_ready;

  // Plaintext goes to the core with zero latency; byte bus is quiet when idle.
  assign core_ld_state_valid = blk_acc;
  assign core_ld_state_byte  = blk_acc ? blk_byte : 8'h00;

  assign core_ld_key_valid = (st == S_LOAD) && !rkey_cnt[5];
  assign core_ld_key_byte  = core_ld_key_valid ? cache[rkey_cnt[4:0]] : 8'h00;
  assign rkey_acc          = core_ld_key_valid && core_ld_key_ready;

  // Both counters saturate at their limits, so the top bits mean "complete".
  assign load_done = rkey_cnt[5] && blk_cnt[4];
  assign wdog_tc   = (wdog == WDOG_W'(1));
  assign out_acc   = out_valid && out_ready;
  assign blk_fin   = out_acc && (out_cnt == 4'd15);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    st_nxt     = st;
    busy       = 1'b1;
    core_start = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_byte   = 8'h00;
    out_sh     = out_buf << {out_cnt, 3'b000};
    case (st)
      S_IDLE: begin
        busy = 1'b0;
        if (blk_acc) st_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_done) st_nxt = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        st_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (core_done)    st_nxt = S_OUT;
        else if (wdog_tc) st_nxt = S_IDLE;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_byte  = out_sh[127:120];
        out_last  = (out_cnt == 4'd15);
        if (out_ready && out_cnt == 4'd15) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // Key cache, byte counters, watchdog, result buffer and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cache[i] <= 8'h00;
      key_cnt    <= '0;
      blk_cnt    <= '0;
      rkey_cnt   <= '0;
      out_cnt    <= '0;
      wdog       <= '0;
      out_buf    <= '0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (key_acc) begin
        cache[key_cnt] <= key_byte;
        key_cnt        <= key_cnt + 5'd1;
        if (key_cnt == 5'd0)  key_loaded <= 1'b0;
        if (key_cnt == 5'd31) key_loaded <= 1'b1;
      end
      if (blk_acc)  blk_cnt  <= blk_cnt + 5'd1;
      if (rkey_acc) rkey_cnt <= rkey_cnt + 6'd1;
      case (st)
        S_START: wdog <= '1;
        S_WAIT: begin
          if (core_done) begin
            out_buf <= core_state_out;
            out_cnt <= '0;
          end else if (wdog_tc) begin
            err      <= 1'b1;
            blk_cnt  <= '0;
            rkey_cnt <= '0;
          end else begin
            wdog <= wdog - WDOG_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_cnt <= out_cnt + 4'd1;
            if (out_cnt == 4'd15) begin
              blk_cnt  <= '0;
              rkey_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES_SEQ_BLKCNT_EN
  // Count blocks whose last ciphertext byte reached the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       blk_done_cnt <= '0;
    else if (blk_fin) blk_done_cnt <= blk_done_cnt + 32'd1;
  end
`else
  // No completion counter in this build; blk_fin has no other consumer.
  logic unused_blk_fin;
  assign unused_blk_fin = blk_fin;
`endif

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Self-checking bench for aes_seq_ctrl with a behavioural core stub.
module tb_aes_seq_ctrl;

  localparam int WDOG_W = 4;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk, rst_n;
  logic         key_valid, key_ready, blk_valid, blk_ready;
  logic [7:0]   key_byte, blk_byte, out_byte;
  logic         out_valid, out_last, out_ready, busy, key_loaded, err;
  logic         core_ld_key_valid, core_ld_key_ready, core_ld_state_valid, core_ld_state_ready;
  logic [7:0]   core_ld_key_byte, core_ld_state_byte;
  logic         core_start, core_done;
  logic [127:0] core_state_out;
`ifdef AES_SEQ_BLKCNT_EN
  logic [31:0]  blk_done_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int blocks_done = 0;

  aes_seq_ctrl #(.WDOG_W(WDOG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_byte(key_byte), .key_ready(key_ready),
    .blk_valid(blk_valid), .blk_byte(blk_byte), .blk_ready(blk_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .key_loaded(key_loaded), .err(err),
    .core_ld_key_valid(core_ld_key_valid), .core_ld_key_byte(core_ld_key_byte),
    .core_ld_key_ready(core_ld_key_ready),
    .core_ld_state_valid(core_ld_state_valid), .core_ld_state_byte(core_ld_state_byte),
    .core_ld_state_ready(core_ld_state_ready),
    .core_start(core_start), .core_state_out(core_state_out), .core_done(core_done)
`ifdef AES_SEQ_BLKCNT_EN
    , .blk_done_cnt(blk_done_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference cipher: the real FIPS-197 C.3 answer for the known vector,
  // otherwise a cheap key-dependent mix so key/plaintext delivery is verified.
  function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] p);
    if (k == C3_KEY && p == C3_PT) return C3_CT;
    return p ^ k[255:128] ^ {k[63:0], k[127:64]};
  endfunction

  // Core stub: collects replayed key and plaintext bytes, answers after a random latency.
  logic [255:0] cap_key;
  logic [127:0] cap_pt;
  int  kcnt, scnt, lat;
  bit  pend, no_done;
  initial begin
    core_ld_key_ready = 0; core_ld_state_ready = 0; core_done = 0; core_state_out = '0;
    cap_key = '0; cap_pt = '0; kcnt = 0; scnt = 0; lat = 0; pend = 0; no_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        kcnt = 0; scnt = 0; pend = 0;
      end else begin
        if (core_ld_key_valid && core_ld_key_ready) begin
          cap_key = {cap_key[247:0], core_ld_key_byte}; kcnt++;
        end
        if (core_ld_state_valid && core_ld_state_ready) begin
          cap_pt = {cap_pt[119:0], core_ld_state_byte}; scnt++;
        end
        if (core_start) begin
          chk("core_key_bytes", kcnt, 32);
          chk("core_pt_bytes", scnt, 16);
          kcnt = 0; scnt = 0;
          pend = !no_done;
          lat = $urandom_range(0, 8);
        end
      end
      @(posedge clk); #1;
      core_done = 0;
      core_ld_key_ready   = ($urandom_range(0, 3) != 0);
      core_ld_state_ready = ($urandom_range(0, 3) != 0);
      if (pend && rst_n) begin
        if (lat == 0) begin
          core_done = 1; core_state_out = cipher(cap_key, cap_pt); pend = 0;
        end else lat--;
      end
    end
  end

  task automatic send_key(input logic [255:0] k, input bit with_blk);
    logic [255:0] t;
    int n;
    bit acc;
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        key_valid = 0; @(posedge clk); #1;
      end
      t = k << (8 * i);
      key_valid = 1; key_byte = t[255:248];
      if (with_blk) begin blk_valid = 1; blk_byte = C3_PT[127:120]; end
      n = 0;
      do begin
        @(negedge clk);
        acc = key_ready;
        if (with_blk) chk("blk_ready_while_key", blk_ready, 0);
        n++;
        @(posedge clk); #1;
      end while (!acc && n < 200);
      if (!acc) begin chk("key_accept_timeout", 0, 1); key_valid = 0; blk_valid = 0; return; end
    end
    key_valid = 0; blk_valid = 0;
    @(negedge clk);
    chk("key_loaded", key_loaded, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [127:0] p);
    logic [127:0] t;
    int n;
    bit acc;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        blk_valid = 0; @(posedge clk); #1;
      end
      t = p << (8 * i);
      blk_valid = 1; blk_byte = t[127:120];
      n = 0;
      do begin
        @(negedge clk);
        acc = blk_ready;
        if (acc) begin
          chk("state_valid", core_ld_state_valid, 1);
          chk("state_byte", core_ld_state_byte, t[127:120]);
        end
        n++;
        @(posedge clk); #1;
      end while (!acc && n < 200);
      if (!acc) begin chk("blk_accept_timeout", 0, 1); blk_valid = 0; return; end
    end
    blk_valid = 0;
  endtask

  task automatic recv(input logic [127:0] exp, input bit stall3);
    logic [127:0] t;
    int n, stall;
    bit got;
    for (int i = 0; i < 16; i++) begin
      t = exp << (8 * i);
      if (stall3 && i == 3) stall = 5;
      else stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      got = 0; n = 0;
      while (!got) begin
        out_ready = (stall == 0);
        @(negedge clk);
        if (i > 0) chk("out_valid_held", out_valid, 1);
        if (out_valid) begin
          chk("out_byte", out_byte, t[127:120]);
          chk("out_last", out_last, (i == 15));
          chk("busy_out", busy, 1);
          if (out_ready) got = 1; else stall--;
        end else begin
          n++;
          if (n > 400) begin
            chk("out_timeout", 0, 1); out_ready = 0; @(posedge clk); #1; return;
          end
        end
        @(posedge clk); #1;
      end
    end
    out_ready = 0;
    blocks_done++;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("out_valid_after", out_valid, 0);
    chk("key_loaded_kept", key_loaded, 1);
`ifdef AES_SEQ_BLKCNT_EN
    chk("blk_done_cnt", blk_done_cnt, blocks_done);
`endif
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_loaded"}, key_loaded, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_byte"}, out_byte, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_ld_key_valid"}, core_ld_key_valid, 0);
    chk({tag, "_ld_key_byte"}, core_ld_key_byte, 0);
    chk({tag, "_ld_state_valid"}, core_ld_state_valid, 0);
    chk({tag, "_ld_state_byte"}, core_ld_state_byte, 0);
`ifdef AES_SEQ_BLKCNT_EN
    chk({tag, "_blk_done_cnt"}, blk_done_cnt, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  logic [255:0] key_m;
  logic [127:0] pt_m, t128;
  int n, sent;

  initial begin
    rst_n = 0; key_valid = 0; key_byte = 0; blk_valid = 0; blk_byte = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Key and plaintext offered together before any key: key wins.
    send_key(C3_KEY, 1'b1);
    key_m = C3_KEY;
    send_block(C3_PT);
    recv(cipher(key_m, C3_PT), 1'b1);

    // Second block on the cached key.
    send_block(C3_PT);
    recv(C3_CT, 1'b0);

    // Random keys and blocks against the reference.
    for (int it = 0; it < 5; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        for (int w = 0; w < 8; w++) key_m = {key_m[223:0], 32'($urandom)};
        send_key(key_m, 1'b0);
      end
      pt_m = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      send_block(pt_m);
      recv(cipher(key_m, pt_m), 1'b0);
    end

    // Watchdog: core never answers.
    no_done = 1;
    pt_m = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    send_block(pt_m);
    n = 0;
    do begin @(negedge clk); n++; end while (!core_start && n < 200);
    chk("start_seen", core_start, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("err_before_tc", err, 0);
      if (k == 16) begin
        chk("err_after_tc", err, 1);
        chk("busy_after_tc", busy, 0);
        chk("key_loaded_after_tc", key_loaded, 1);
        chk("key_ready_after_tc", key_ready, 1);
      end
    end
    @(posedge clk); #1;
    no_done = 0;
    send_block(pt_m);
    recv(cipher(key_m, pt_m), 1'b0);
    chk("err_sticky", err, 1);

    // Reset in the middle of key replay.
    send_key(C3_KEY, 1'b0);
    key_m = C3_KEY;
    sent = 0; n = 0;
    while (kcnt < 10 && n < 500) begin
      if (sent < 16) begin
        t128 = C3_PT << (8 * sent);
        blk_valid = 1; blk_byte = t128[127:120];
      end else blk_valid = 0;
      @(negedge clk);
      if (blk_valid && blk_ready) sent++;
      n++;
      @(posedge clk); #1;
    end
    chk("mid_load_reached", (kcnt >= 10), 1);
    chk("mid_load_busy", busy, 1);
    rst_n = 0; blk_valid = 0;
    #1;
    chk_reset_outputs("mid_reset");
    blocks_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    send_key(C3_KEY, 1'b0);
    send_block(C3_PT);
    recv(C3_CT, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
